// File: rtl/ifetch.sv
// Instruction fetch: one-outstanding halfword fetcher feeding a small prefetch FIFO toward decode.
// Define IFETCH_BYPASS_EN to let an unsquashed parcel skip the empty FIFO straight onto ins.
module ifetch #(
    parameter int            RV       = 32,
    parameter int            DEPTH    = 2,
    parameter logic [RV-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mreq,
    output logic [RV-1:0] maddr,
    input  logic          mack,
    input  logic [15:0]   mdata,
    input  logic          mfault,
    input  logic          stall,
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          ins_fault,
    output logic          idone
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [RV-1:0] START_PC = RESET_PC & ~(RV'(1));

    typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;

    req_state_t    req_state, req_state_next;
    logic [15:0]   fifo_data  [DEPTH];
    logic [RV-1:0] fifo_pc    [DEPTH];
    logic          fifo_fault [DEPTH];
    logic [PW-1:0] rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
    logic [CW-1:0] count, count_next;
    logic [RV-1:0] fetch_pc, fetch_pc_next, maddr_next;
    logic          squash, squash_next, halted, halted_next;
    logic          accept, bypass, push, pop, outstanding_next, raise;

    assign mreq = (req_state == REQ_WAIT);

`ifdef IFETCH_BYPASS_EN
    assign bypass = accept && !mfault && (count == '0) && !stall;
`else
    assign bypass = 1'b0;
`endif

    // Response acceptance, FIFO bookkeeping and the decision to raise the next request.
    // The raise check uses next-cycle occupancy so a pop or push at this edge is already counted.
    always_comb begin
        accept = mreq && mack && !squash && !redirect;
        push   = accept && !bypass;
        pop    = (count != '0) && !stall && !redirect;

        if (redirect) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            count_next  = count + CW'(push) - CW'(pop);
            rd_ptr_next = pop  ? rd_ptr + PW'(1) : rd_ptr;
            wr_ptr_next = push ? wr_ptr + PW'(1) : wr_ptr;
        end

        squash_next = squash;
        if (mreq && mack) begin
            squash_next = 1'b0;
        end else if (redirect && mreq) begin
            squash_next = 1'b1;
        end

        halted_next = redirect ? 1'b0 : (halted || (accept && mfault));

        fetch_pc_next = fetch_pc;
        if (redirect) begin
            fetch_pc_next = redirect_pc & ~(RV'(1));
        end else if (accept) begin
            fetch_pc_next = fetch_pc + RV'(2);
        end

        outstanding_next = mreq && !mack;
        raise = !outstanding_next && !redirect && !halted_next && (count_next < DEPTH_C);
        req_state_next = (outstanding_next || raise) ? REQ_WAIT : REQ_IDLE;
        maddr_next = raise ? fetch_pc_next : maddr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_state <= REQ_IDLE;
            maddr     <= START_PC;
            fetch_pc  <= START_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            squash    <= 1'b0;
            halted    <= 1'b0;
            ins       <= '0;
            ins_pc    <= '0;
            ins_fault <= 1'b0;
            idone     <= 1'b0;
        end else begin
            req_state <= req_state_next;
            maddr     <= maddr_next;
            fetch_pc  <= fetch_pc_next;
            count     <= count_next;
            rd_ptr    <= rd_ptr_next;
            wr_ptr    <= wr_ptr_next;
            squash    <= squash_next;
            halted    <= halted_next;
            idone     <= pop || bypass;
            if (pop) begin
                ins       <= fifo_data[rd_ptr];
                ins_pc    <= fifo_pc[rd_ptr];
                ins_fault <= fifo_fault[rd_ptr];
            end else if (bypass) begin
                ins       <= mdata;
                ins_pc    <= maddr;
                ins_fault <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; occupancy alone says which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr]  <= mdata;
            fifo_pc[wr_ptr]    <= maddr;
            fifo_fault[wr_ptr] <= mfault;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios then random stall/redirect/fault traffic,
// checked against an in-order queue model of accepted fetches.
module tb_ifetch;
    localparam int          RV       = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h100;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] data;
        logic        fault;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mreq;
    logic [31:0] maddr;
    logic        mack = 1'b0;
    logic [15:0] mdata = '0;
    logic        mfault = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [15:0] ins;
    logic [31:0] ins_pc;
    logic        ins_fault;
    logic        idone;

    int checks = 0;
    int failures = 0;

    entry_t      exp_q[$];
    logic [31:0] del_log[$];
    logic [31:0] exp_pc;
    bit          halted_m, squash_m;
    bit          req_active;
    int          req_age, cur_lat;
    logic [31:0] req_addr;

    bit          stall_v, redirect_v, rand_mode, auto_redir, auto_fired;
    logic [31:0] rpc_v, fault_addr, auto_pc;
    int          lat;

    bit          last_new_req, last_idone, last_idone_fault;
    logic [31:0] last_new_addr, last_idone_pc;
    int          new_req_count = 0;
    int          acc_count = 0;

    ifetch #(.RV(RV), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .mreq(mreq), .maddr(maddr), .mack(mack), .mdata(mdata), .mfault(mfault),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ins(ins), .ins_pc(ins_pc), .ins_fault(ins_fault), .idone(idone)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_data(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'hC3A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc     = RESET_PC;
        halted_m   = 0;
        squash_m   = 0;
        req_active = 0;
        req_age    = 0;
        mack       = 1'b0;
        mfault     = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
    endtask

    // One clock: play memory, drive knobs, advance the model, then judge the registered outputs.
    task automatic run_cycle();
        bit     mack_now;
        int     q_pre;
        entry_t e;
        last_new_req = 0;
        if (mreq === 1'b1 && !req_active) begin
            req_active    = 1;
            req_age       = 0;
            req_addr      = maddr;
            cur_lat       = rand_mode ? int'($urandom_range(0, 3)) : lat;
            last_new_req  = 1;
            last_new_addr = maddr;
            new_req_count++;
            check("req_addr", maddr, exp_pc);
            check("req_not_halted", halted_m, 0);
            check("req_room", exp_q.size() < DEPTH, 1);
        end else if (req_active) begin
            check("mreq_held", mreq, 1);
            check("maddr_stable", maddr, req_addr);
        end

        mack_now    = req_active && (req_age >= cur_lat);
        mack        = mack_now;
        mdata       = mem_data(req_addr);
        mfault      = mack_now && ((req_addr == fault_addr) ||
                                   (rand_mode && $urandom_range(0, 29) == 0));
        stall       = stall_v;
        redirect    = redirect_v;
        redirect_pc = rpc_v;
        q_pre       = exp_q.size();
        if (auto_redir && mack_now && q_pre > 0) begin
            redirect    = 1'b1;
            stall       = 1'b0;
            redirect_pc = auto_pc;
            auto_redir  = 0;
            auto_fired  = 1;
        end

        if (redirect) begin
            exp_q.delete();
            halted_m = 0;
        end
        if (mack_now) begin
            if (redirect || squash_m) begin
                squash_m = 0;
            end else begin
                e.pc = req_addr;
                e.data = mdata;
                e.fault = mfault;
                exp_q.push_back(e);
                acc_count++;
                exp_pc = req_addr + 32'd2;
                if (mfault) halted_m = 1;
            end
            req_active = 0;
        end
        if (redirect) begin
            if (req_active) squash_m = 1;
            exp_pc = redirect_pc & ~32'd1;
        end

        @(posedge clk);
        #1;
        if (req_active) req_age++;
        last_idone = idone;
        if (redirect) begin
            check("idone_redirect", idone, 0);
        end else if (stall) begin
            check("idone_stall", idone, 0);
        end else if (q_pre > 0) begin
            check("idone_deliver", idone, 1);
        end
        if (idone === 1'b1) begin
            check("idone_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ins", ins, e.data);
                check("ins_pc", ins_pc, e.pc);
                check("ins_fault", ins_fault, e.fault);
                del_log.push_back(ins_pc);
                last_idone_pc    = ins_pc;
                last_idone_fault = ins_fault;
            end
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_v = 1;
        rpc_v      = pc;
        run_cycle();
        redirect_v = 0;
    endtask

    task automatic wait_new_req(input string tag, input logic [31:0] addr_exp, input int max_cycles);
        bit found = 0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            run_cycle();
            found = last_new_req;
        end
        check({tag, "_seen"}, found, 1);
        if (found) check(tag, last_new_addr, addr_exp);
    endtask

    task automatic wait_idone(input string tag, input logic [31:0] pc_exp, input logic fault_exp,
                              input int max_cycles);
        bit found = 0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            run_cycle();
            found = last_idone;
        end
        check({tag, "_seen"}, found, 1);
        if (found) begin
            check(tag, last_idone_pc, pc_exp);
            check({tag, "_fault"}, last_idone_fault, fault_exp);
        end
    endtask

    initial begin
        int base;
        int mark;
        bit found;
        bit hit;

        model_reset();
        lat = 1;
        fault_addr = 32'h1;
        rand_mode = 0;
        stall_v = 0;
        redirect_v = 0;
        rpc_v = '0;
        auto_redir = 0;
        auto_pc = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mreq", mreq, 0);
        check("rst_maddr", maddr, RESET_PC);
        check("rst_idone", idone, 0);
        check("rst_ins", ins, 0);
        check("rst_ins_pc", ins_pc, 0);
        check("rst_ins_fault", ins_fault, 0);
        reset = 1'b1;
        run_cycle();
        check("first_mreq", mreq, 1);
        check("first_maddr", maddr, 32'h100);

        wait_idone("seq_pc0", 32'h100, 0, 20);
        wait_idone("seq_pc1", 32'h102, 0, 20);
        wait_idone("seq_pc2", 32'h104, 0, 20);

        $display("[TB] stall fill");
        stall_v = 1;
        pulse_redirect(32'h200);
        base = acc_count;
        repeat (10) run_cycle();
        check("stall_fill_count", acc_count - base, DEPTH);
        check("stall_mreq_low", mreq, 0);
        stall_v = 0;
        run_cycle();
        check("stall_rel_idone0", last_idone, 1);
        check("stall_rel_pc0", last_idone_pc, 32'h200);
        run_cycle();
        check("stall_rel_idone1", last_idone, 1);
        check("stall_rel_pc1", last_idone_pc, 32'h202);
        check("resume_req", last_new_req, 1);
        check("resume_addr", last_new_addr, 32'h204);

        $display("[TB] redirect with outstanding request");
        lat = 3;
        pulse_redirect(32'h100);
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            run_cycle();
            found = last_new_req && (last_new_addr == 32'h108);
        end
        check("t3_req108_seen", found, 1);
        mark = del_log.size();
        pulse_redirect(32'h2001);
        wait_new_req("t3_redirect_addr", 32'h2000, 10);
        wait_idone("t3_first_pc", 32'h2000, 0, 20);
        hit = 0;
        for (int i = mark; i < del_log.size(); i++) if (del_log[i] == 32'h108) hit = 1;
        check("t3_no_108", hit, 0);

        $display("[TB] redirect coincident with mack and delivery");
        lat = 1;
        stall_v = 1;
        pulse_redirect(32'h300);
        auto_pc = 32'h400;
        auto_fired = 0;
        auto_redir = 1;
        for (int i = 0; i < 20 && !auto_fired; i++) run_cycle();
        check("t4_fired", auto_fired, 1);
        stall_v = 0;
        check("t4_idone_low", last_idone, 0);
        wait_new_req("t4_new_addr", 32'h400, 3);
        wait_idone("t4_first_pc", 32'h400, 0, 10);

        $display("[TB] fetch fault");
        fault_addr = 32'h10A;
        pulse_redirect(32'h108);
        wait_idone("t5_pc108", 32'h108, 0, 20);
        wait_idone("t5_pc10a", 32'h10A, 1, 20);
        base = new_req_count;
        repeat (10) run_cycle();
        check("t5_halted_reqs", new_req_count - base, 0);
        check("t5_mreq_low", mreq, 0);
        fault_addr = 32'h1;
        pulse_redirect(32'h40);
        wait_new_req("t5_restart", 32'h40, 5);
        wait_idone("t5_restart_pc", 32'h40, 0, 10);

        $display("[TB] address wrap and async reset");
        pulse_redirect(32'hFFFF_FFFE);
        wait_new_req("wrap_top", 32'hFFFF_FFFE, 6);
        wait_new_req("wrap_zero", 32'h0, 6);
        lat = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            run_cycle();
            found = (mreq === 1'b1) && (idone === 1'b1);
        end
        check("busy_seen", found, 1);
        #2 reset = 1'b0;
        #1;
        check("async_mreq", mreq, 0);
        check("async_idone", idone, 0);
        check("async_maddr", maddr, RESET_PC);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_cycle();
        check("rerun_mreq", mreq, 1);
        check("rerun_maddr", maddr, RESET_PC);

        $display("[TB] random traffic");
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            stall_v    = ($urandom_range(0, 9) < 3);
            redirect_v = ($urandom_range(0, 39) == 0);
            rpc_v      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h7)) : $urandom;
            run_cycle();
        end
        redirect_v = 0;
        stall_v = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
